// File: rtl/sparse_pe_scheduler.sv
// Job sequencer for the sparse-convolution PE: sweeps every (feature-group, weight)
// pair once per channel over a valid/ready handshake, then waits out the PE pipeline.
module sparse_pe_scheduler #(
  parameter int double_word_length = 16,
  parameter int max_feature        = 52,
  parameter int max_weight         = 28,
  parameter int group_size         = 4,
  parameter int drain_cycles       = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [double_word_length-1:0] in_channel,
  input  logic [double_word_length-1:0] feature_valid_num,
  input  logic [double_word_length-1:0] weight_valid_num,
  output logic                          busy,
  output logic                          issue_valid,
  input  logic                          issue_ready,
  output logic [double_word_length-1:0] curr_pixel,
  output logic [double_word_length-1:0] curr_weight,
  output logic [group_size-1:0]         feat_mask,
  output logic [double_word_length-1:0] ch_idx,
  output logic                          first_pair,
  output logic                          last_pair,
  output logic                          done
);

  localparam int dcw = (drain_cycles > 1) ? $clog2(drain_cycles) : 1;
  localparam logic [double_word_length-1:0] max_f  = double_word_length'(max_feature);
  localparam logic [double_word_length-1:0] max_w  = double_word_length'(max_weight);
  localparam logic [double_word_length-1:0] gs     = double_word_length'(group_size);
  localparam logic [double_word_length-1:0] one_dw = double_word_length'(1);
  localparam logic [group_size-1:0]         one_g  = group_size'(1);
  localparam logic [dcw-1:0]                dlast  = dcw'(drain_cycles - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t state_reg, state_next;

  logic [double_word_length-1:0] g_reg, g_next;
  logic [double_word_length-1:0] wvn_reg, wvn_next;
  logic [double_word_length-1:0] nch_reg, nch_next;
  logic [double_word_length-1:0] rem_reg, rem_next;
  logic [double_word_length-1:0] p_reg, p_next;
  logic [double_word_length-1:0] w_reg, w_next;
  logic [double_word_length-1:0] ch_reg, ch_next;
  logic [dcw-1:0]                dcnt_reg, dcnt_next;
  logic                          first_reg, first_next;
  logic                          last_reg, last_next;

  logic [double_word_length-1:0] fvn_clamp, wvn_clamp, nch_calc, g_calc, rem_calc;
  logic [group_size-1:0]         tail_mask;

  assign fvn_clamp = (feature_valid_num > max_f) ? max_f : feature_valid_num;
  assign wvn_clamp = (weight_valid_num > max_w) ? max_w : weight_valid_num;
  assign nch_calc  = (in_channel == '0) ? one_dw : in_channel;
  assign g_calc    = (fvn_clamp + gs - one_dw) / gs;
  assign rem_calc  = fvn_clamp % gs;
  assign tail_mask = (one_g << rem_reg) - one_g;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      g_reg     <= '0;
      wvn_reg   <= '0;
      nch_reg   <= '0;
      rem_reg   <= '0;
      p_reg     <= '0;
      w_reg     <= '0;
      ch_reg    <= '0;
      dcnt_reg  <= '0;
      first_reg <= 1'b0;
      last_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      g_reg     <= g_next;
      wvn_reg   <= wvn_next;
      nch_reg   <= nch_next;
      rem_reg   <= rem_next;
      p_reg     <= p_next;
      w_reg     <= w_next;
      ch_reg    <= ch_next;
      dcnt_reg  <= dcnt_next;
      first_reg <= first_next;
      last_reg  <= last_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    g_next     = g_reg;
    wvn_next   = wvn_reg;
    nch_next   = nch_reg;
    rem_next   = rem_reg;
    p_next     = p_reg;
    w_next     = w_reg;
    ch_next    = ch_reg;
    dcnt_next  = dcnt_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          g_next     = g_calc;
          wvn_next   = wvn_clamp;
          nch_next   = nch_calc;
          rem_next   = rem_calc;
          p_next     = '0;
          w_next     = '0;
          ch_next    = '0;
          state_next = (g_calc != '0 && wvn_clamp != '0) ? ISSUE : DONE;
        end
      end
      ISSUE: begin
        if (issue_ready) begin
          // Pixel innermost, then weight, then channel; the final pair holds its indices.
          if (p_reg != g_reg - one_dw) begin
            p_next = p_reg + one_dw;
          end else if (w_reg != wvn_reg - one_dw) begin
            p_next = '0;
            w_next = w_reg + one_dw;
          end else if (ch_reg != nch_reg - one_dw) begin
            p_next  = '0;
            w_next  = '0;
            ch_next = ch_reg + one_dw;
          end else begin
            dcnt_next  = '0;
            state_next = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (dcnt_reg == dlast) state_next = DONE;
        else                   dcnt_next  = dcnt_reg + 1'b1;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase

    // Flags are computed for the pair that will be presented next cycle.
    first_next = (state_next == ISSUE) && (p_next == '0) && (w_next == '0) && (ch_next == '0);
    last_next  = (state_next == ISSUE) && (p_next == g_next - one_dw) &&
                 (w_next == wvn_next - one_dw) && (ch_next == nch_next - one_dw);
  end

  always_comb begin
    feat_mask = '0;
    if (state_reg == ISSUE)
      feat_mask = (p_reg == g_reg - one_dw && rem_reg != '0) ? tail_mask : '1;
  end

  assign busy        = (state_reg != IDLE);
  assign issue_valid = (state_reg == ISSUE);
  assign done        = (state_reg == DONE);
  assign curr_pixel  = p_reg;
  assign curr_weight = w_reg;
  assign ch_idx      = ch_reg;
  assign first_pair  = first_reg;
  assign last_pair   = last_reg;

endmodule

// File: tb/tb_sparse_pe_scheduler.sv
// Directed bench: a job table swept with a reference index walk, plus an async-reset abort sequence.
module tb_sparse_pe_scheduler;

  localparam int dwl   = 16;
  localparam int gsz   = 4;
  localparam int drain = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [dwl-1:0]  in_channel = '0;
  logic [dwl-1:0]  feature_valid_num = '0;
  logic [dwl-1:0]  weight_valid_num = '0;
  logic            busy;
  logic            issue_valid;
  logic            issue_ready = 1'b0;
  logic [dwl-1:0]  curr_pixel;
  logic [dwl-1:0]  curr_weight;
  logic [gsz-1:0]  feat_mask;
  logic [dwl-1:0]  ch_idx;
  logic            first_pair;
  logic            last_pair;
  logic            done;

  sparse_pe_scheduler #(
    .double_word_length(dwl), .max_feature(52), .max_weight(28),
    .group_size(gsz), .drain_cycles(drain)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .in_channel(in_channel),
    .feature_valid_num(feature_valid_num), .weight_valid_num(weight_valid_num),
    .busy(busy), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .curr_pixel(curr_pixel), .curr_weight(curr_weight), .feat_mask(feat_mask),
    .ch_idx(ch_idx), .first_pair(first_pair), .last_pair(last_pair), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int fvn;
    int wvn;
    int ch;
    int stall;      // 1: ready pattern 1,0,0,1 repeating
    int mid_start;  // 1: pulse start with other inputs during the sweep
    int exp_g;
    int exp_w;
    int exp_nch;
    int exp_pairs;
    int exp_tail;
  } job_t;

  job_t jobs [7];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic run_job(input int idx);
    int ep, ew, ech, acc, cyc, budget, rdy;
    job_t j;
    j = jobs[idx];
    @(negedge clk);
    start = 1'b1;
    feature_valid_num = dwl'(j.fvn);
    weight_valid_num  = dwl'(j.wvn);
    in_channel        = dwl'(j.ch);
    @(negedge clk);
    start = 1'b0;
    ep = 0; ew = 0; ech = 0; acc = 0; cyc = 0;
    budget = j.exp_pairs * 3 + 20;
    if (j.exp_pairs == 0) begin
      check("empty_done", int'(done), 1);
      check("empty_busy", int'(busy), 1);
      check("empty_valid", int'(issue_valid), 0);
      @(negedge clk);
      check("empty_after_busy", int'(busy), 0);
      check("empty_after_done", int'(done), 0);
    end else begin
      while (acc < j.exp_pairs && cyc < budget) begin
        rdy = (j.stall != 0) ? int'(cyc % 4 == 0 || cyc % 4 == 3) : 1;
        issue_ready = rdy[0];
        if (j.mid_start != 0 && cyc == 3) begin
          start = 1'b1;
          feature_valid_num = 16'd1;
          weight_valid_num  = 16'd1;
          in_channel        = 16'd1;
        end else begin
          start = 1'b0;
        end
        check("valid", int'(issue_valid), 1);
        check("busy", int'(busy), 1);
        check("pixel", int'(curr_pixel), ep);
        check("weight", int'(curr_weight), ew);
        check("ch_idx", int'(ch_idx), ech);
        check("mask", int'(feat_mask), (ep == j.exp_g - 1) ? j.exp_tail : 15);
        check("first", int'(first_pair), int'(acc == 0));
        check("last", int'(last_pair), int'(acc == j.exp_pairs - 1));
        if (rdy != 0) begin
          acc++;
          if (acc < j.exp_pairs) begin
            ep++;
            if (ep == j.exp_g) begin
              ep = 0;
              ew++;
              if (ew == j.exp_w) begin
                ew = 0;
                ech++;
              end
            end
          end
        end
        cyc++;
        @(negedge clk);
      end
      start = 1'b0;
      issue_ready = 1'b0;
      if (acc < j.exp_pairs) check("timeout_pairs", acc, j.exp_pairs);
      for (int k = 0; k <= drain + 1; k++) begin
        check("drain_valid", int'(issue_valid), 0);
        check("drain_done", int'(done), int'(k == drain));
        check("drain_busy", int'(busy), int'(k <= drain));
        if (k < drain + 1) @(negedge clk);
      end
      check("hold_pixel", int'(curr_pixel), ep);
      check("hold_weight", int'(curr_weight), ew);
    end
    $display("job %0d fvn=%0d wvn=%0d ch=%0d pairs=%0d accepted=%0d cycles=%0d",
             idx, j.fvn, j.wvn, j.ch, j.exp_pairs, acc, cyc);
  endtask

  initial begin
    //            fvn wvn ch stall mid  G  W  nch pairs tail
    jobs[0] = '{10,  3,  1, 0,    0,   3, 3,  1,  9,   3};
    jobs[1] = '{10,  3,  1, 1,    0,   3, 3,  1,  9,   3};
    jobs[2] = '{ 0,  5,  1, 0,    0,   0, 5,  1,  0,  15};
    jobs[3] = '{ 8,  0,  1, 0,    0,   2, 0,  1,  0,  15};
    jobs[4] = '{60, 40,  0, 0,    0,  13, 28, 1, 364, 15};
    jobs[5] = '{ 5,  2,  2, 0,    1,   2, 2,  2,  8,   1};
    jobs[6] = '{ 4,  1,  1, 0,    0,   1, 1,  1,  1,  15};

    repeat (2) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_valid", int'(issue_valid), 0);
    check("rst_done", int'(done), 0);
    check("rst_mask", int'(feat_mask), 0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_job(i);

    // Abort mid-sweep: hold at the 4th pair (p0,w1), then assert reset asynchronously.
    @(negedge clk);
    start = 1'b1;
    feature_valid_num = 16'd10;
    weight_valid_num  = 16'd3;
    in_channel        = 16'd1;
    issue_ready       = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_pre_weight", int'(curr_weight), 1);
    check("abort_pre_valid", int'(issue_valid), 1);
    #1 rst = 1'b1;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_valid", int'(issue_valid), 0);
    check("abort_pixel", int'(curr_pixel), 0);
    check("abort_weight", int'(curr_weight), 0);
    check("abort_ch", int'(ch_idx), 0);
    check("abort_mask", int'(feat_mask), 0);
    check("abort_first", int'(first_pair), 0);
    check("abort_last", int'(last_pair), 0);
    check("abort_done", int'(done), 0);
    @(negedge clk);
    rst = 1'b0;
    issue_ready = 1'b0;
    for (int k = 0; k < drain + 3; k++) begin
      check("abort_no_done", int'(done), 0);
      check("abort_idle", int'(busy), 0);
      @(negedge clk);
    end
    $display("abort sequence complete");

    run_job(6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
